// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//
// Dual-issue round-robin arbiter in front of a 1024 x 32 two-port data
// memory. Up to two requesters are granted per cycle, one on memory port A
// (primary signals) and one on port B (the *_reg signals). Each granted
// request is checked against the memory's key_access word. The read data
// comes back one cycle after the accept, straight from the memory's own
// output register.
//
// The memory writes on every clock. Any port without a good granted
// request is therefore parked on PARK_ADDR and writes zero to that
// scratch word.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               per-requester handshake (accept = valid & ready)
//   req_we/req_addr/req_wdata/req_key per-requester command, flattened per index
//   rsp_valid/rsp_id/rsp_err/rsp_rdata  per-port response, bit/slice 0 = port A
//   mem_read_address, mem_write_address, mem_data_in              port A drive
//   mem_read_address_reg, mem_write_address_reg, mem_data_in_reg  port B drive
//   mem_data_out, mem_data_out_reg    registered memory read data
//   key_access                        expected access key from the memory
//   err_count                         saturating count of rejected requests
module mem_access_arbiter #(
    parameter int              NREQ      = 4,
    parameter int              AW        = 10,
    parameter int              DW        = 32,
    parameter int              IDW       = 2,
    parameter logic [AW-1:0]   PARK_ADDR = 10'h3FF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_we,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_wdata,
    input  logic [NREQ*16-1:0]  req_key,
    output logic [1:0]          rsp_valid,
    output logic [2*IDW-1:0]    rsp_id,
    output logic [1:0]          rsp_err,
    output logic [2*DW-1:0]     rsp_rdata,
    output logic [AW-1:0]       mem_read_address,
    output logic [AW-1:0]       mem_write_address,
    output logic [DW-1:0]       mem_data_in,
    output logic [AW-1:0]       mem_read_address_reg,
    output logic [AW-1:0]       mem_write_address_reg,
    output logic [DW-1:0]       mem_data_in_reg,
    input  logic [DW-1:0]       mem_data_out,
    input  logic [DW-1:0]       mem_data_out_reg,
    input  logic [15:0]         key_access,
    output logic [7:0]          err_count
);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_next;
    logic [IDW-1:0] cand;
    logic           a_found, b_found;
    logic [IDW-1:0] a_idx, b_idx;
    logic [AW-1:0]  a_addr, b_addr;
    logic [DW-1:0]  a_wdata, b_wdata;
    logic [15:0]    a_key, b_key;
    logic           a_we, b_we;
    logic           a_bad, b_bad;
    logic           a_grant, b_grant;
    logic           conflict;
    logic [8:0]     err_sum;
    logic [7:0]     err_next;
    logic [1:0]     rsp_read;

    // Port A takes the first valid requester at or after rr_ptr. Port B
    // takes the next valid one after A, wrapping, and never A itself.
    always_comb begin
        a_found = 1'b0;
        a_idx   = '0;
        b_found = 1'b0;
        b_idx   = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!a_found && req_valid[cand]) begin
                a_found = 1'b1;
                a_idx   = cand;
            end
        end
        for (int k = 1; k < NREQ; k++) begin
            cand = IDW'((int'(a_idx) + k) % NREQ);
            if (a_found && !b_found && req_valid[cand]) begin
                b_found = 1'b1;
                b_idx   = cand;
            end
        end
    end

    // Pull the winners' command fields out of the flattened buses.
    always_comb begin
        a_addr  = AW'(req_addr  >> (int'(a_idx) * AW));
        b_addr  = AW'(req_addr  >> (int'(b_idx) * AW));
        a_wdata = DW'(req_wdata >> (int'(a_idx) * DW));
        b_wdata = DW'(req_wdata >> (int'(b_idx) * DW));
        a_key   = 16'(req_key   >> (int'(a_idx) * 16));
        b_key   = 16'(req_key   >> (int'(b_idx) * 16));
        a_we    = req_we[a_idx];
        b_we    = req_we[b_idx];
    end

    // Port B is held off when both ports hit the same word and either one
    // writes. This keeps two writes from racing and keeps a read from seeing
    // stale data. The deferred requester becomes the port A winner next
    // cycle, because rr_ptr then lands just after this cycle's A.
    // Reset masks every grant so that req_ready stays low while rst_n is low.
    always_comb begin
        conflict  = b_found && (b_addr == a_addr) && (a_we || b_we);
        a_grant   = a_found && rst_n;
        b_grant   = b_found && !conflict && rst_n;
        a_bad     = (a_key != key_access) || (a_addr == PARK_ADDR);
        b_bad     = (b_key != key_access) || (b_addr == PARK_ADDR);
        req_ready = '0;
        if (a_grant) req_ready[a_idx] = 1'b1;
        if (b_grant) req_ready[b_idx] = 1'b1;
    end

    // Memory drive. Bad or absent requests park the port, so the forced
    // write on every clock only ever touches the scratch word.
    always_comb begin
        mem_read_address      = PARK_ADDR;
        mem_write_address     = PARK_ADDR;
        mem_data_in           = '0;
        mem_read_address_reg  = PARK_ADDR;
        mem_write_address_reg = PARK_ADDR;
        mem_data_in_reg       = '0;
        if (a_grant && !a_bad) begin
            if (a_we) begin
                mem_write_address = a_addr;
                mem_data_in       = a_wdata;
            end else begin
                mem_read_address  = a_addr;
            end
        end
        if (b_grant && !b_bad) begin
            if (b_we) begin
                mem_write_address_reg = b_addr;
                mem_data_in_reg       = b_wdata;
            end else begin
                mem_read_address_reg  = b_addr;
            end
        end
    end

    // Next pointer is one past the last winner in priority order (B if it
    // was granted, otherwise A). The error counter saturates at 255.
    always_comb begin
        rr_next = rr_ptr;
        if (b_grant) begin
            rr_next = IDW'((int'(b_idx) + 1) % NREQ);
        end else if (a_grant) begin
            rr_next = IDW'((int'(a_idx) + 1) % NREQ);
        end
        err_sum  = {1'b0, err_count} + 9'(a_grant && a_bad) + 9'(b_grant && b_bad);
        err_next = (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
    end

    // The response tags line up with the memory's one-cycle read register.
    // Reset drops any response that is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            err_count <= '0;
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_err   <= '0;
            rsp_read  <= '0;
        end else begin
            rr_ptr    <= rr_next;
            err_count <= err_next;
            rsp_valid <= {b_grant, a_grant};
            rsp_id    <= {b_idx, a_idx};
            rsp_err   <= {b_grant && b_bad, a_grant && a_bad};
            rsp_read  <= {!b_we, !a_we};
        end
    end

    // Read data passes through only for a valid, good read. Everything else
    // returns zero.
    always_comb begin
        rsp_rdata = '0;
        if (rsp_valid[0] && rsp_read[0] && !rsp_err[0]) rsp_rdata[DW-1:0]    = mem_data_out;
        if (rsp_valid[1] && rsp_read[1] && !rsp_err[1]) rsp_rdata[2*DW-1:DW] = mem_data_out_reg;
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter
//
// Bench for mem_access_arbiter. It contains a model of the two-port memory
// (preloaded with word i = i). A reference model keeps its own shadow copy
// of the memory, a round-robin pointer and an error counter. The model
// derives grants, port drives and responses from the arbitration rules.
// Directed scenarios run first, then a randomized phase.
module tb_mem_access_arbiter;

    localparam int             NREQ = 4;
    localparam int             AW   = 10;
    localparam int             DW   = 32;
    localparam int             IDW  = 2;
    localparam logic [AW-1:0]  PARK = 10'h3FF;
    localparam logic [15:0]    KEY  = 16'h5A3C;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid, req_ready, req_we;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ*16-1:0]  req_key;
    logic [1:0]          rsp_valid, rsp_err;
    logic [2*IDW-1:0]    rsp_id;
    logic [2*DW-1:0]     rsp_rdata;
    logic [AW-1:0]       mem_read_address, mem_write_address;
    logic [AW-1:0]       mem_read_address_reg, mem_write_address_reg;
    logic [DW-1:0]       mem_data_in, mem_data_in_reg;
    logic [DW-1:0]       mem_data_out, mem_data_out_reg;
    logic [7:0]          err_count;

    // Requester state, one entry per requester
    logic                r_valid [NREQ];
    logic                r_we    [NREQ];
    logic [AW-1:0]       r_addr  [NREQ];
    logic [DW-1:0]       r_wdata [NREQ];
    logic [15:0]         r_key   [NREQ];

    // Reference model state
    logic [DW-1:0]       gmem [1024];
    int                  m_rr, m_err;
    int                  ga, gb;
    logic [1:0]          exp_valid;
    int                  exp_id    [2];
    logic                exp_err   [2];
    logic [DW-1:0]       exp_rdata [2];
    logic                acc [NREQ];
    logic [NREQ-1:0]     last_ready;
    logic [AW-1:0]       last_wa;
    logic [DW-1:0]       last_din;

    int                  n_checks = 0;
    int                  n_fail   = 0;

    mem_access_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW), .PARK_ADDR(PARK)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_we                (req_we),
        .req_addr              (req_addr),
        .req_wdata             (req_wdata),
        .req_key               (req_key),
        .rsp_valid             (rsp_valid),
        .rsp_id                (rsp_id),
        .rsp_err               (rsp_err),
        .rsp_rdata             (rsp_rdata),
        .mem_read_address      (mem_read_address),
        .mem_write_address     (mem_write_address),
        .mem_data_in           (mem_data_in),
        .mem_read_address_reg  (mem_read_address_reg),
        .mem_write_address_reg (mem_write_address_reg),
        .mem_data_in_reg       (mem_data_in_reg),
        .mem_data_out          (mem_data_out),
        .mem_data_out_reg      (mem_data_out_reg),
        .key_access            (KEY),
        .err_count             (err_count)
    );

    always #5 clk = ~clk;

    // Pack the per-requester arrays onto the flattened DUT buses
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = r_valid[i];
            req_we[i]              = r_we[i];
            req_addr[i*AW +: AW]   = r_addr[i];
            req_wdata[i*DW +: DW]  = r_wdata[i];
            req_key[i*16 +: 16]    = r_key[i];
        end
    end

    // Two-port memory: both ports write every clock, and reads are
    // registered. The first clock edge preloads word i with the value i.
    logic [DW-1:0] pmem [1024];
    logic          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) pmem[i] <= DW'(i);
            loaded <= 1'b1;
        end else begin
            pmem[mem_write_address]     <= mem_data_in;
            pmem[mem_write_address_reg] <= mem_data_in_reg;
            mem_data_out                <= pmem[mem_read_address];
            mem_data_out_reg            <= pmem[mem_read_address_reg];
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_bad(input int i);
        return (r_key[i] != KEY) || (r_addr[i] == PARK);
    endfunction

    // The model lists the valid requesters in rotation order starting at its
    // pointer. A is the first entry and B is the second, unless B collides
    // with A on a write.
    task automatic compare_comb();
        int              elig[$];
        int              g[2];
        int              idx;
        logic [NREQ-1:0] er;
        logic [AW-1:0]   ra[2], wa[2];
        logic [DW-1:0]   din[2];
        ga = -1;
        gb = -1;
        if (rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (r_valid[idx]) elig.push_back(idx);
            end
            if (elig.size() > 0) ga = elig[0];
            if (elig.size() > 1) begin
                gb = elig[1];
                if (r_addr[gb] == r_addr[ga] && (r_we[ga] || r_we[gb])) gb = -1;
            end
        end
        er = '0;
        if (ga >= 0) er = er | (NREQ'(1) << ga);
        if (gb >= 0) er = er | (NREQ'(1) << gb);
        last_ready = req_ready;
        last_wa    = mem_write_address;
        last_din   = mem_data_in;
        check_output("req_ready", req_ready, er);
        g[0] = ga;
        g[1] = gb;
        for (int p = 0; p < 2; p++) begin
            ra[p]  = PARK;
            wa[p]  = PARK;
            din[p] = '0;
            if (g[p] >= 0 && !is_bad(g[p])) begin
                if (r_we[g[p]]) begin
                    wa[p]  = r_addr[g[p]];
                    din[p] = r_wdata[g[p]];
                end else begin
                    ra[p]  = r_addr[g[p]];
                end
            end
        end
        check_output("portA_raddr", mem_read_address,      ra[0]);
        check_output("portA_waddr", mem_write_address,     wa[0]);
        check_output("portA_din",   mem_data_in,           din[0]);
        check_output("portB_raddr", mem_read_address_reg,  ra[1]);
        check_output("portB_waddr", mem_write_address_reg, wa[1]);
        check_output("portB_din",   mem_data_in_reg,       din[1]);
    endtask

    // Accept edge. Compute the responses from the shadow memory before this
    // cycle's writes, then apply the writes and advance the pointer.
    task automatic commit();
        int g[2];
        g[0] = ga;
        g[1] = gb;
        exp_valid = '0;
        for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (g[p] >= 0) begin
                exp_valid[p] = 1'b1;
                exp_id[p]    = g[p];
                exp_err[p]   = is_bad(g[p]);
                exp_rdata[p] = (!exp_err[p] && !r_we[g[p]]) ? gmem[r_addr[g[p]]] : '0;
                acc[g[p]]    = 1'b1;
                if (exp_err[p]) m_err = (m_err < 255) ? m_err + 1 : 255;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (g[p] >= 0 && !is_bad(g[p]) && r_we[g[p]]) gmem[r_addr[g[p]]] = r_wdata[g[p]];
        end
        if (gb >= 0)      m_rr = (gb + 1) % NREQ;
        else if (ga >= 0) m_rr = (ga + 1) % NREQ;
    endtask

    task automatic check_regs();
        check_output("rsp_valid", rsp_valid, exp_valid);
        for (int p = 0; p < 2; p++) begin
            if (exp_valid[p]) begin
                check_output("rsp_id",  rsp_id[p*IDW +: IDW], exp_id[p]);
                check_output("rsp_err", rsp_err[p],            exp_err[p]);
                check_output("rsp_rdata", rsp_rdata[p*DW +: DW], exp_rdata[p]);
            end else begin
                check_output("rsp_rdata_idle", rsp_rdata[p*DW +: DW], 0);
            end
        end
        check_output("err_count", err_count, m_err);
    endtask

    // One clock: this is entered on a falling edge after the inputs are set.
    task automatic run_cycle();
        #1;
        compare_comb();
        @(posedge clk);
        commit();
        @(negedge clk);
        check_regs();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            r_valid[i] = 1'b0;
            acc[i]     = 1'b0;
        end
        m_rr      = 0;
        m_err     = 0;
        exp_valid = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [15:0] k);
        r_valid[i] = 1'b1;
        r_we[i]    = we;
        r_addr[i]  = a;
        r_wdata[i] = d;
        r_key[i]   = k;
    endtask

    // Give a new random request to each requester that is idle or was just
    // accepted. A pending request stays unchanged.
    task automatic apply_stimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (!r_valid[i] || acc[i]) begin
                r_valid[i] = ($urandom_range(0, 9) < 6);
                r_we[i]    = 1'($urandom_range(0, 1));
                r_addr[i]  = ($urandom_range(0, 15) == 0) ? PARK : AW'($urandom_range(0, 15));
                r_wdata[i] = $urandom;
                r_key[i]   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : KEY;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) gmem[i] = DW'(i);
        for (int i = 0; i < NREQ; i++) begin
            r_we[i]    = 1'b0;
            r_addr[i]  = '0;
            r_wdata[i] = '0;
            r_key[i]   = '0;
        end
        clear_model();

        // Values held during reset
        #1;
        check_output("reset_rsp_valid", rsp_valid, 0);
        check_output("reset_err_count", err_count, 0);
        check_output("reset_req_ready", req_ready, 0);
        check_output("reset_park_wa",   mem_write_address, PARK);
        @(negedge clk);
        apply_reset();

        // Single read of word 5 on port A
        set_req(0, 1'b0, 10'd5, 32'h0, KEY);
        run_cycle();
        r_valid[0] = 1'b0;
        check_output("t1_park_wa",   last_wa, PARK);
        check_output("t1_park_din",  last_din, 0);
        check_output("t1_rsp_valid", rsp_valid, 2'b01);
        check_output("t1_rsp_id",    rsp_id[IDW-1:0], 0);
        check_output("t1_rdata",     rsp_rdata[DW-1:0], 32'h5);

        // All four requesters read distinct words, so two are granted per cycle
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i + 1), 32'h0, KEY);
        run_cycle();
        check_output("t2_grant0", last_ready, 4'b0011);
        run_cycle();
        check_output("t2_grant1", last_ready, 4'b1100);
        check_output("t2_rsp_valid", rsp_valid, 2'b11);
        run_cycle();
        check_output("t2_grant2", last_ready, 4'b0011);
        run_cycle();
        clear_model();
        @(negedge clk);

        // Write and read of the same word in one cycle: the read is deferred
        apply_reset();
        set_req(1, 1'b1, 10'd7, 32'hDEADBEEF, KEY);
        set_req(2, 1'b0, 10'd7, 32'h0, KEY);
        run_cycle();
        check_output("t3_grant_w", last_ready, 4'b0010);
        r_valid[1] = 1'b0;
        run_cycle();
        check_output("t3_grant_r", last_ready, 4'b0100);
        r_valid[2] = 1'b0;
        check_output("t3_rdata", rsp_rdata[DW-1:0], 32'hDEADBEEF);

        // Bad key, then a park-address access
        apply_reset();
        set_req(3, 1'b0, 10'd9, 32'h0, 16'h0031);
        run_cycle();
        check_output("t4_grant", last_ready, 4'b1000);
        check_output("t4_err",   rsp_err[0], 1'b1);
        check_output("t4_rdata", rsp_rdata[DW-1:0], 0);
        check_output("t4_count", err_count, 8'd1);
        set_req(3, 1'b1, PARK, 32'h12345678, KEY);
        run_cycle();
        r_valid[3] = 1'b0;
        check_output("t4_park_err",   rsp_err[0], 1'b1);
        check_output("t4_park_count", err_count, 8'd2);
        check_output("t4_mem9",       pmem[9], 32'h9);

        // Saturation of the error counter
        apply_reset();
        set_req(0, 1'b0, 10'd3, 32'h0, 16'h0031);
        repeat (300) run_cycle();
        r_valid[0] = 1'b0;
        check_output("t5_saturate", err_count, 8'd255);

        // Reset asserted while a response is showing
        apply_reset();
        set_req(0, 1'b0, 10'd12, 32'h0, KEY);
        set_req(1, 1'b0, 10'd13, 32'h0, 16'h0031);
        run_cycle();
        check_output("t6_pre_valid", rsp_valid, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t6_rsp_valid", rsp_valid, 0);
        check_output("t6_rsp_id",    rsp_id, 0);
        check_output("t6_rsp_err",   rsp_err, 0);
        check_output("t6_rdata",     rsp_rdata, 0);
        check_output("t6_err_count", err_count, 0);
        check_output("t6_req_ready", req_ready, 0);
        check_output("t6_park_a",    mem_read_address, PARK);
        check_output("t6_park_b",    mem_write_address_reg, PARK);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) run_cycle();

        // Randomized traffic against the model
        apply_reset();
        repeat (400) begin
            apply_stimulus();
            run_cycle();
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Dual-issue round-robin arbiter that shares the 1024 x 32 two-port data memory between NREQ requesters. It drives both memory port pairs (primary and `_reg`) directly and grants up to two requests per cycle. It checks each request's access key against the memory's `key_access` output. It returns read data with a fixed one-cycle latency. Idle ports are parked on a reserved scratch word, because the memory writes on every clock unconditionally.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `AW`, 10: address width.
- `DW`, 32: data width.
- `IDW`, 2: requester-id width, equal to clog2(NREQ).
- `PARK_ADDR`, 10'h3FF: scratch word that absorbs idle-port writes; requester access to it is forbidden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  grant; a request is accepted in a cycle where valid & ready.
- `req_we`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- `req_wdata`  in  NREQ*DW  flattened write data.
- `req_key`  in  NREQ*16  flattened access keys.
- `rsp_valid`  out  2  response valid, bit 0 = port A, bit 1 = port B.
- `rsp_id`  out  2*IDW  requester id owning each response.
- `rsp_err`  out  2  key mismatch, or PARK_ADDR access.
- `rsp_rdata`  out  2*DW  read data; 0 for writes and for errors.
- `mem_read_address`, `mem_write_address`  out  AW  port A address drive.
- `mem_data_in`  out  DW  port A write data.
- `mem_read_address_reg`, `mem_write_address_reg`  out  AW  port B address drive.
- `mem_data_in_reg`  out  DW  port B write data.
- `mem_data_out`, `mem_data_out_reg`  in  DW  memory read data, registered inside the memory.
- `key_access`  in  16  expected key from the memory.
- `err_count`  out  8  saturating count of rejected requests.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid[i]` is 1.
- **Port A winner.** The first eligible index at or after `rr_ptr`, searching modulo NREQ.
- **Port B winner.** The next eligible index after the port A winner, wrapping, never equal to it.
- **Port B conflict deferral.** Port B is not granted when its address equals port A's address and either request is a write. The deferred requester keeps its valid and retries next cycle.
- **Bad requests.** A request is bad if `req_key` != `key_access` or `req_addr` == `PARK_ADDR`.
  - Bad requests are still granted and consume their slot.
  - The port is parked for that cycle.
  - The response carries `rsp_err`=1 and `rdata`=0.
  - `err_count` increments by 1 per bad request (2 if both are bad), saturating at 255.
- **Granted good write.** `write_address`=addr and `data_in`=wdata. `read_address` is parked.
- **Granted good read.** `read_address`=addr. `write_address` is parked with `data_in`=0.
- **Parked port.** `read_address`=`write_address`=`PARK_ADDR`, `data_in`=0.
- **Round-robin pointer.** `rr_ptr` is updated to (highest-priority-order last granted index + 1) mod NREQ. It is unchanged if nothing is granted.
- **Response registers.** Per port, a registered {valid, id, err, was_read} is captured at the accept edge.
- **Response data.** `rsp_rdata` for a port = `mem_data_out`(_reg) when valid & was_read & !err, else 0.
- **Reset values** (asynchronous assert): `rr_ptr`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_err`=0, `err_count`=0, `req_ready`=0 while `rst_n`=0. Both memory ports are parked during reset.
- **Reset mid-operation.** In-flight responses are discarded; no `rsp_valid` appears after release. A write whose accept edge coincided with reset assertion is not guaranteed to land.

## Timing
- `req_ready` and the memory address/data drives are combinational from `req_*`, `key_access` and `rr_ptr`. `req_ready` must not depend on any requester output.
- Requesters hold all `req_*` fields stable while valid and not accepted.
- **Accept in cycle N:**
  - Write lands in the memory at the end of cycle N.
  - `rsp_valid` is asserted in cycle N+1 for exactly one cycle.
  - Read data is presented in N+1.
- **Throughput.** Two accepts per cycle, sustained, when there is no conflict.
- **Read-after-write.** Write accepted in N, read of the same address accepted in N+1 or later returns the new data.
- **Same-cycle conflict.** Handled by deferral, so stale data is never returned.
- No backpressure on responses; the consumer must always accept.

## Test plan
- Reset, then requester 0 reads addr 5 → `rsp_valid[0]`=1 with `rsp_id`=0 and `rdata`=32'h5 exactly one cycle after accept. Meanwhile the memory write address = 10'h3FF and `data_in`=0.
- Requesters 0..3 valid every cycle, all reading distinct addresses 1..4 → grants {0,1}, {2,3}, {0,1}…, two responses per cycle, `rr_ptr` rotating.
- Requester 1 writes 32'hDEADBEEF to 7 while requester 2 reads 7 in the same cycle → only 1 is granted. Requester 2 is granted next cycle and reads 32'hDEADBEEF.
- Requester 3 presents key 16'h0031 → granted, `rsp_err`=1, `rdata`=0, memory unchanged, `err_count`=1. A request to addr 10'h3FF gives the same behaviour.
- 300 consecutive bad requests → `err_count` saturates at 255.
- `rst_n` asserted one cycle after accept of a read → no `rsp_valid`, and all outputs are at their reset values immediately (asynchronous).
